i2c_slave: RTL

- I2C target (responder) for the team's I2C bus; the counterpart of our I2C master.
- Responds to one 7-bit address and receives write bytes, handing each to the user.
- Supplies read bytes from the user and drives SDA open-drain.
- Sits between the physical pins and a local register file/peripheral; no clock stretching, SCL is input only.

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_line_sync.sv | 34 +++
 rtl/i2c_slave.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target (slave) block.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_ADDR,
        RX_DATA,
        ACK_RX,
        TX_DATA,
        MACK
    } i2c_state_e;

    localparam logic       I2C_ACK          = 1'b0;
    localparam logic       I2C_NACK         = 1'b1;
    localparam logic [6:0] I2C_GENCALL_ADDR = 7'h00;

endpackage

// File: rtl/i2c_line_sync.sv
// Multi-flop synchronizer for one bus line plus single-cycle rise/fall strobes.
// Every flop presets to 1 so that reset looks like an idle, pulled-up bus.
module i2c_line_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;

    assign sync_d = {sync_q[STAGES-2:0], line_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: one 7-bit address, byte-wise write/read hand-off, open-drain SDA, no stretching.
// Optional general-call acceptance (address byte 8'h00) with I2C_SLAVE_GENCALL_EN.
// IDLE: wait START | ADDR: shift address | ACK_ADDR: ack address, fetch first read byte
// RX_DATA: shift write byte | ACK_RX: ack write byte | TX_DATA: drive read byte | MACK: master ack/nack
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR   = 7'h50,
    parameter int         SYNC_STAGES  = 2,
    parameter int         SYS_CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       rw,
    output logic       busy,
`ifdef I2C_SLAVE_GENCALL_EN
    output logic       gencall,
`endif
    output logic       stop_det
);

    if (SYNC_STAGES < 2 || SYS_CLK_FREQ < 2_000_000) begin : g_param_check
        $error("i2c_slave: SYNC_STAGES must be >= 2 and SYS_CLK_FREQ >= 20x SCL");
    end

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;

    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk), .rst_n(rst_n), .line_i(scl),
        .level_o(scl_s), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk), .rst_n(rst_n), .line_i(sda),
        .level_o(sda_s), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    i2c_state_e state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       oe_q, oe_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;
    logic       rx_valid_q, rx_valid_d;
    logic       stop_det_q, stop_det_d;
    logic       gencall_q, gencall_d;
    logic       tx_req_c;
    logic [7:0] shift_in;
    logic       start_cond, stop_cond;

    assign start_cond = sda_fall & scl_s;
    assign stop_cond  = sda_rise & scl_s;
    assign shift_in   = {shift_q[6:0], sda_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd7;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            oe_q       <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            stop_det_q <= 1'b0;
            gencall_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            oe_q       <= oe_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            stop_det_q <= stop_det_d;
            gencall_q  <= gencall_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        oe_d       = oe_q;
        rw_d       = rw_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        stop_det_d = 1'b0;
        gencall_d  = gencall_q;
        tx_req_c   = 1'b0;

        // Bus conditions override whatever bit handling the state would do.
        if (stop_cond) begin
            state_d    = IDLE;
            oe_d       = 1'b0;
            busy_d     = 1'b0;
            stop_det_d = 1'b1;
            gencall_d  = 1'b0;
        end else if (start_cond) begin
            state_d   = ADDR;
            oe_d      = 1'b0;
            bit_cnt_d = 4'd7;
            gencall_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: if (scl_rise) begin
                    shift_d = shift_in;
                    if (bit_cnt_q == 4'd0) begin
                        if (shift_in[7:1] == SLAVE_ADDR) begin
                            rw_d    = shift_in[0];
                            busy_d  = 1'b1;
                            state_d = ACK_ADDR;
`ifdef I2C_SLAVE_GENCALL_EN
                        end else if (shift_in == {I2C_GENCALL_ADDR, 1'b0}) begin
                            rw_d      = 1'b0;
                            busy_d    = 1'b1;
                            gencall_d = 1'b1;
                            state_d   = ACK_ADDR;
`endif
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end
                end
                // oe_q distinguishes the fall that starts the ack slot from the one that ends it.
                ACK_ADDR: if (scl_rise && oe_q && rw_q) begin
                    tx_req_c = 1'b1;
                    shift_d  = tx_data;
                end else if (scl_fall) begin
                    if (!oe_q) begin
                        oe_d = 1'b1;
                    end else begin
                        bit_cnt_d = 4'd7;
                        if (rw_q) begin
                            oe_d    = ~shift_q[7];
                            state_d = TX_DATA;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = RX_DATA;
                        end
                    end
                end
                RX_DATA: if (scl_rise) begin
                    shift_d = shift_in;
                    if (bit_cnt_q == 4'd0) begin
                        rx_data_d  = shift_in;
                        rx_valid_d = 1'b1;
                        state_d    = ACK_RX;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end
                end
                ACK_RX: if (scl_fall) begin
                    if (!oe_q) begin
                        oe_d = 1'b1;
                    end else begin
                        oe_d      = 1'b0;
                        bit_cnt_d = 4'd7;
                        state_d   = RX_DATA;
                    end
                end
                TX_DATA: if (scl_fall) begin
                    if (bit_cnt_q == 4'd0) begin
                        oe_d    = 1'b0;
                        state_d = MACK;
                    end else begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        oe_d      = ~shift_q[6];
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end
                end
                MACK: if (scl_rise) begin
                    if (sda_s == I2C_ACK) begin
                        tx_req_c = 1'b1;
                        shift_d  = tx_data;
                    end else begin
                        busy_d  = 1'b0;
                        oe_d    = 1'b0;
                        state_d = IDLE;
                    end
                end else if (scl_fall) begin
                    oe_d      = ~shift_q[7];
                    bit_cnt_d = 4'd7;
                    state_d   = TX_DATA;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign sda      = oe_q ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_c;
    assign rw       = rw_q;
    assign busy     = busy_q;
    assign stop_det = stop_det_q;
`ifdef I2C_SLAVE_GENCALL_EN
    assign gencall  = gencall_q;
`else
    logic unused_gencall;
    assign unused_gencall = gencall_q ^ gencall_d;
`endif

endmodule
